lsu_access_ctrl: RTL and testbench
==================================

LSU_ACCESS_CTRL -- requirements
Module: lsu_access_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, meaning cycles waited for i_ack before abort (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_req_valid in 1 (core memory request), i_is_store in 1 (1 store, 0 load), i_funct3 in 3 (RV32I load/store width code), i_addr in 32 (byte address), i_rs2_data in 32 (raw store data).
REQ-005 SHALL have ports o_lsu_addr out 16 (word-aligned address to LSU), o_st_data out 32 (lane-aligned store data), o_bmask out 4 (byte enables), o_lsu_wren out 1, o_lsu_rden out 1.
REQ-006 SHALL have ports i_ld_data in 32 (raw LSU read word) and i_ack in 1 (LSU access complete).
REQ-007 SHALL have ports o_stall out 1 (freeze core), o_ld_data out 32 (extended load result), o_ld_valid out 1 (load result valid), o_fault out 1 (access fault).

Function
REQ-008 SHALL implement FSM IDLE, ACCESS, DONE; reset state IDLE.
REQ-009 SHALL flag a fault on i_req_valid in IDLE when i_addr[31:16]!=0, funct3 in {011,110,111}, halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-010 SHALL, on a fault in IDLE, assert o_fault combinationally that cycle, issue no access, hold o_stall=0, and stay IDLE.
REQ-011 SHALL, on a valid non-faulting request in IDLE, latch addr, funct3, is_store, aligned store data and mask, and enter ACCESS on the next edge.
REQ-012 SHALL drive o_stall=1 combinationally in IDLE with an accepted request, and throughout ACCESS.
REQ-013 SHALL drive o_lsu_addr={addr[15:2],2'b00} from the latched request.
REQ-014 SHALL, in ACCESS, hold o_lsu_wren=is_store and o_lsu_rden=~is_store steadily until i_ack is sampled high; both SHALL be 0 in IDLE and DONE.
REQ-015 SHALL align stores as: SB -> rs2[7:0] replicated x4, mask 1<<addr[1:0]; SH -> rs2[15:0] replicated x2, mask 0011 (addr[1]=0) or 1100; SW -> rs2, mask 1111.
REQ-016 SHALL drive o_bmask=0000 outside ACCESS.
REQ-017 SHALL, on i_ack in ACCESS, register the load lane into o_ld_data and enter DONE: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through, lane selected by latched addr[1:0].
REQ-018 SHALL, in DONE, drive o_stall=0, o_ld_valid=1 for loads only (exactly one cycle), then return to IDLE unconditionally.
REQ-019 SHALL ignore i_req_valid in DONE so the retiring request is never re-issued.
REQ-020 SHALL hold o_ld_data until the next load completes; stores SHALL NOT modify it.
REQ-021 SHALL ignore i_ack outside ACCESS.
REQ-022 SHALL give minimum load latency of 3 cycles (accept, ACCESS with same-edge ack, DONE).

Reset
REQ-023 SHALL, with i_rst sampled high, force state IDLE, o_ld_data=0, o_ld_valid=0, o_lsu_wren=0, o_lsu_rden=0, o_bmask=0000, o_stall=0, o_fault=0, timeout counter=0.
REQ-024 SHALL, on reset mid-ACCESS, abandon the access; an i_ack arriving after reset SHALL be ignored.

Configuration
REQ-025 SHALL, with macro LSU_TIMEOUT_EN defined, count ACCESS cycles from 0; on reaching ACK_TIMEOUT without i_ack, drop wren/rden, enter DONE, set o_ld_data=0, pulse o_fault for one cycle in DONE, and suppress o_ld_valid.
REQ-026 SHALL, without LSU_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely for i_ack.

Verification
REQ-027 SHALL cover: LB at 0x0003, i_ld_data=0x80FF_1234, ack after 2 cycles -> o_ld_data=0xFFFF_FF80, o_ld_valid one cycle, o_stall high 3 cycles.
REQ-028 SHALL cover: SH at 0x0102, rs2=0xDEAD_BEEF -> o_lsu_addr=0x0100, o_st_data=0xBEEF_BEEF, o_bmask=1100, wren held until ack.
REQ-029 SHALL cover: LW at 0x0006 -> o_fault=1 same cycle, no wren/rden, o_stall=0.
REQ-030 SHALL cover: LHU at 0x7802 with i_ld_data=0x8001_0000 -> o_ld_data=0x0000_8001.
REQ-031 SHALL cover: i_rst asserted second cycle of ACCESS, ack next cycle -> IDLE, no o_ld_valid, all outputs at reset values.
REQ-032 SHALL cover (LSU_TIMEOUT_EN, ACK_TIMEOUT=4): load, no ack -> rden drops after 4 ACCESS cycles, o_fault pulse, o_ld_data=0.

Source files
------------

// File: rtl/lsu_access_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_access_ctrl
//
// Purpose:
//   Bridges RV32I core load/store requests to a simple word-oriented LSU
//   port. It checks alignment and range, lane-aligns store data and byte
//   enables, and holds the access until the LSU acknowledges it. It then
//   returns the sign- or zero-extended load result and stalls the core
//   while the access is outstanding.
//
// Optional feature:
//   LSU_TIMEOUT_EN -- when defined, an access that sees no i_ack within
//   ACK_TIMEOUT cycles is aborted and reported as a fault. When undefined,
//   no counter exists and ACCESS waits indefinitely for i_ack.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), synchronous active-high reset
//   i_req_valid        core request present
//   i_is_store         1 = store, 0 = load
//   i_funct3           RV32I width code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   i_addr             byte address (only the low 64 KiB is legal)
//   i_rs2_data         raw store data
//   o_lsu_addr         word-aligned LSU address
//   o_st_data          lane-aligned store data
//   o_bmask            byte enables (zero outside ACCESS)
//   o_lsu_wren/rden    LSU write/read strobes (ACCESS only)
//   i_ld_data          raw LSU read word
//   i_ack              LSU access complete (only looked at in ACCESS)
//   o_stall            freeze core while a request is being serviced
//   o_ld_data          extended load result, held until the next load
//   o_ld_valid         one-cycle pulse when a load result is ready
//   o_fault            access fault (illegal request, or timeout)
//   o_dbg_state        current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Handshake:
//   A request is taken in IDLE when i_req_valid is high and it does not
//   fault. o_stall is high that same cycle and stays high through ACCESS,
//   so the core must hold its request until o_stall drops. The LSU sees
//   wren/rden held steady through ACCESS. The cycle in which i_ack is
//   sampled high completes the access. DONE is the retire cycle: o_stall
//   is low and a new request presented then is ignored.
// -----------------------------------------------------------------------------
module lsu_access_ctrl #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rs2_data,
  output logic [15:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_bmask,
  output logic        o_lsu_wren,
  output logic        o_lsu_rden,
  input  logic [31:0] i_ld_data,
  input  logic        i_ack,
  output logic        o_stall,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_fault,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state;

  // Latched request
  logic [15:0] addr_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic [31:0] st_data_q;
  logic [3:0]  bmask_q;
  logic [31:0] ld_data_q;

  // Request decode (combinational, from core inputs)
  logic        req_fault;
  logic        accept;
  logic [31:0] st_aligned;
  logic [3:0]  mask_aligned;
  logic [31:0] ld_extended;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Set when the current DONE cycle was reached by timeout rather than ack.
  logic        timed_out;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  logic [CNT_W-1:0] to_cnt;
  logic             to_flag_q;
  assign timed_out = to_flag_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (ACK_TIMEOUT == 0);
  assign timed_out = 1'b0;
`endif

  // Illegal: outside the 64 KiB window, reserved width codes, or misaligned.
  always_comb begin
    req_fault = 1'b0;
    if (i_addr[31:16] != 16'h0000) req_fault = 1'b1;
    case (i_funct3)
      3'b011, 3'b110, 3'b111: req_fault = 1'b1;
      default: ;
    endcase
    if ((i_funct3[1:0] == 2'b01) && i_addr[0])              req_fault = 1'b1;
    if ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00)) req_fault = 1'b1;
  end

  // Reset wins over a same-cycle request so no stall leaks out during reset.
  assign accept = (state == ST_IDLE) && i_req_valid && !req_fault && !i_rst;

  // Store data is replicated across lanes; byte enables pick the target lane.
  // Loads latch the same mask so the LSU sees which bytes are being read.
  always_comb begin
    st_aligned   = i_rs2_data;
    mask_aligned = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        st_aligned   = {4{i_rs2_data[7:0]}};
        mask_aligned = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        st_aligned   = {2{i_rs2_data[15:0]}};
        mask_aligned = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_aligned   = i_rs2_data;
        mask_aligned = 4'b1111;
      end
    endcase
  end

  // Load lane select and extension, driven by the latched request.
  always_comb begin
    ld_byte = i_ld_data[7:0];
    case (addr_q[1:0])
      2'b00: ld_byte = i_ld_data[7:0];
      2'b01: ld_byte = i_ld_data[15:8];
      2'b10: ld_byte = i_ld_data[23:16];
      2'b11: ld_byte = i_ld_data[31:24];
      default: ;
    endcase
    ld_half = addr_q[1] ? i_ld_data[31:16] : i_ld_data[15:0];
    case (funct3_q)
      3'b000:  ld_extended = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_extended = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_extended = {24'h000000, ld_byte};
      3'b101:  ld_extended = {16'h0000, ld_half};
      default: ld_extended = i_ld_data;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      addr_q     <= 16'h0000;
      funct3_q   <= 3'b000;
      is_store_q <= 1'b0;
      st_data_q  <= 32'h0000_0000;
      bmask_q    <= 4'b0000;
      ld_data_q  <= 32'h0000_0000;
`ifdef LSU_TIMEOUT_EN
      to_cnt     <= '0;
      to_flag_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q     <= i_addr[15:0];
            funct3_q   <= i_funct3;
            is_store_q <= i_is_store;
            st_data_q  <= st_aligned;
            bmask_q    <= mask_aligned;
            state      <= ST_ACCESS;
`ifdef LSU_TIMEOUT_EN
            to_cnt     <= '0;
            to_flag_q  <= 1'b0;
`endif
          end
        end

        ST_ACCESS: begin
          if (i_ack) begin
            if (!is_store_q) ld_data_q <= ld_extended;
            state <= ST_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (to_cnt == CNT_LAST) begin
            // Aborted load leaves a defined zero result. A store never
            // touches the load result register, even when it times out.
            if (!is_store_q) ld_data_q <= 32'h0000_0000;
            to_flag_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        ST_DONE: begin
          // Unconditional: a request seen here belongs to the retiring
          // instruction and must not be re-issued.
          state <= ST_IDLE;
`ifdef LSU_TIMEOUT_EN
          to_flag_q <= 1'b0;
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    o_lsu_addr  = {addr_q[15:2], 2'b00};
    o_st_data   = st_data_q;
    o_bmask     = (state == ST_ACCESS) ? bmask_q : 4'b0000;
    o_lsu_wren  = (state == ST_ACCESS) &&  is_store_q;
    o_lsu_rden  = (state == ST_ACCESS) && !is_store_q;
    o_stall     = accept || (state == ST_ACCESS);
    o_fault     = ((state == ST_IDLE) && i_req_valid && req_fault && !i_rst)
                || ((state == ST_DONE) && timed_out);
    o_ld_valid  = (state == ST_DONE) && !is_store_q && !timed_out;
    o_ld_data   = ld_data_q;
    o_dbg_state = state;
  end

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_access_ctrl
//
// Directed bench for lsu_access_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well clear of the rising edge. Expected
// load results go through exp_q and are popped when o_ld_valid is seen.
// Defining LSU_TIMEOUT_EN also builds the DUT with ACK_TIMEOUT=4 and adds
// the timeout scenario.
// -----------------------------------------------------------------------------
module tb_lsu_access_ctrl;

`ifdef LSU_TIMEOUT_EN
  localparam int TO_CYCLES = 4;
`else
  localparam int TO_CYCLES = 255;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_rs2_data;
  logic [15:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic [3:0]  o_bmask;
  logic        o_lsu_wren;
  logic        o_lsu_rden;
  logic [31:0] i_ld_data;
  logic        i_ack;
  logic        o_stall;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_fault;
  logic [1:0]  o_dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  lsu_access_ctrl #(.ACK_TIMEOUT(TO_CYCLES)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_is_store  (i_is_store),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_rs2_data  (i_rs2_data),
    .o_lsu_addr  (o_lsu_addr),
    .o_st_data   (o_st_data),
    .o_bmask     (o_bmask),
    .o_lsu_wren  (o_lsu_wren),
    .o_lsu_rden  (o_lsu_rden),
    .i_ld_data   (i_ld_data),
    .i_ack       (i_ack),
    .o_stall     (o_stall),
    .o_ld_data   (o_ld_data),
    .o_ld_valid  (o_ld_valid),
    .o_fault     (o_fault),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------------------------------------------------------- clock
  always #5 i_clk = ~i_clk;

  // --------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // --------------------------------------------------------------- drivers
  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2);
    i_req_valid = 1'b1;
    i_is_store  = st;
    i_funct3    = f3;
    i_addr      = addr;
    i_rs2_data  = rs2;
  endtask

  task automatic clear_req();
    i_req_valid = 1'b0;
    i_is_store  = 1'b0;
    i_funct3    = 3'b000;
    i_addr      = 32'h0;
    i_rs2_data  = 32'h0;
  endtask

  // Load: ack_wait ACCESS cycles without ack, then one cycle with ack.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, input int ack_wait, input logic [31:0] exp);
    bit seen;
    exp_q.push_back(exp);
    step(); drive_req(1'b0, f3, addr, 32'h0); #1;
    check({tag, "_stall_accept"}, o_stall, 1'b1);
    check({tag, "_rden_idle"}, o_lsu_rden, 1'b0);
    step(); clear_req(); #1;
    check({tag, "_state_access"}, o_dbg_state, S_ACCESS);
    check({tag, "_lsu_addr"}, o_lsu_addr, {addr[15:2], 2'b00});
    for (int k = 0; k < ack_wait; k++) begin
      check({tag, "_rden_wait"}, o_lsu_rden, 1'b1);
      check({tag, "_stall_wait"}, o_stall, 1'b1);
      step(); #1;
    end
    i_ld_data = word; i_ack = 1'b1; #1;
    check({tag, "_rden_ack"}, o_lsu_rden, 1'b1);
    check({tag, "_stall_ack"}, o_stall, 1'b1);
    step(); i_ack = 1'b0; i_ld_data = 32'hA5A5_A5A5; #1;
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      if (o_ld_valid) seen = 1'b1;
      else begin step(); #1; end
    end
    check({tag, "_ld_valid_seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, "_ld_data"}, o_ld_data, exp_q.pop_front());
      check({tag, "_stall_done"}, o_stall, 1'b0);
      check({tag, "_rden_done"}, o_lsu_rden, 1'b0);
      step(); #1;
      check({tag, "_ld_valid_pulse"}, o_ld_valid, 1'b0);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [15:0] exp_addr,
                          input logic [31:0] exp_data, input logic [3:0] exp_mask,
                          input int ack_wait, input logic [31:0] held_ld);
    step(); drive_req(1'b1, f3, addr, rs2); #1;
    check({tag, "_stall_accept"}, o_stall, 1'b1);
    check({tag, "_bmask_idle"}, o_bmask, 4'b0000);
    step(); clear_req(); #1;
    for (int k = 0; k < ack_wait; k++) begin
      check({tag, "_wren_wait"}, o_lsu_wren, 1'b1);
      step(); #1;
    end
    i_ack = 1'b1; #1;
    check({tag, "_lsu_addr"}, o_lsu_addr, exp_addr);
    check({tag, "_st_data"}, o_st_data, exp_data);
    check({tag, "_bmask"}, o_bmask, exp_mask);
    check({tag, "_wren_ack"}, o_lsu_wren, 1'b1);
    check({tag, "_rden_ack"}, o_lsu_rden, 1'b0);
    step(); i_ack = 1'b0; #1;
    check({tag, "_state_done"}, o_dbg_state, S_DONE);
    check({tag, "_wren_done"}, o_lsu_wren, 1'b0);
    check({tag, "_bmask_done"}, o_bmask, 4'b0000);
    check({tag, "_no_ld_valid"}, o_ld_valid, 1'b0);
    check({tag, "_ld_data_held"}, o_ld_data, held_ld);
    step(); #1;
  endtask

  task automatic do_fault(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr);
    step(); drive_req(st, f3, addr, 32'h1111_2222); #1;
    check({tag, "_fault"}, o_fault, 1'b1);
    check({tag, "_stall"}, o_stall, 1'b0);
    check({tag, "_wren"}, o_lsu_wren, 1'b0);
    check({tag, "_rden"}, o_lsu_rden, 1'b0);
    step(); clear_req(); #1;
    check({tag, "_state_idle"}, o_dbg_state, S_IDLE);
    check({tag, "_fault_clear"}, o_fault, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, o_dbg_state, S_IDLE);
    check({tag, "_ld_data"}, o_ld_data, 32'h0);
    check({tag, "_ld_valid"}, o_ld_valid, 1'b0);
    check({tag, "_wren"}, o_lsu_wren, 1'b0);
    check({tag, "_rden"}, o_lsu_rden, 1'b0);
    check({tag, "_bmask"}, o_bmask, 4'b0000);
    check({tag, "_stall"}, o_stall, 1'b0);
    check({tag, "_fault"}, o_fault, 1'b0);
  endtask

  // -------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "bench timed out");
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    i_rst = 1'b1; i_ack = 1'b0; i_ld_data = 32'h0;
    clear_req();
    // A legal request during reset must not stall the core.
    drive_req(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    step(); step(); #1;
    check_reset_outputs("reset");
    step(); i_rst = 1'b0; clear_req(); #1;

    // Sign-extended byte at the top lane, ack after 2 ACCESS cycles.
    do_load("lb_0003",  3'b000, 32'h0000_0003, 32'h80FF_1234, 1, 32'hFFFF_FF80);
    // Minimum latency: ack in the first ACCESS cycle.
    do_load("lw_0008",  3'b010, 32'h0000_0008, 32'h1234_5678, 0, 32'h1234_5678);
    do_load("lhu_7802", 3'b101, 32'h0000_7802, 32'h8001_0000, 2, 32'h0000_8001);
    do_load("lh_0002",  3'b001, 32'h0000_0002, 32'h8001_0000, 0, 32'hFFFF_8001);
    do_load("lbu_0002", 3'b100, 32'h0000_0002, 32'h80FF_1234, 1, 32'h0000_00FF);

    // Stores leave the last load result (0x000000FF) untouched.
    do_store("sh_0102", 3'b001, 32'h0000_0102, 32'hDEAD_BEEF, 16'h0100,
             32'hBEEF_BEEF, 4'b1100, 2, 32'h0000_00FF);
    do_store("sb_0001", 3'b000, 32'h0000_0001, 32'h1234_5678, 16'h0000,
             32'h7878_7878, 4'b0010, 0, 32'h0000_00FF);
    do_store("sb_0003", 3'b000, 32'h0000_0003, 32'h0000_00AB, 16'h0000,
             32'hABAB_ABAB, 4'b1000, 1, 32'h0000_00FF);
    do_store("sw_0004", 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 16'h0004,
             32'hCAFE_F00D, 4'b1111, 0, 32'h0000_00FF);

    do_fault("lw_0006",   1'b0, 3'b010, 32'h0000_0006);
    do_fault("lh_0001",   1'b0, 3'b001, 32'h0000_0001);
    do_fault("sh_0003",   1'b1, 3'b001, 32'h0000_0003);
    do_fault("sb_10000",  1'b1, 3'b000, 32'h0001_0000);
    do_fault("f3_011",    1'b0, 3'b011, 32'h0000_0000);
    do_fault("f3_110",    1'b0, 3'b110, 32'h0000_0004);

    // A request presented during DONE must be ignored.
    step(); drive_req(1'b0, 3'b100, 32'h0000_0000, 32'h0); #1;
    step(); clear_req(); i_ack = 1'b1; i_ld_data = 32'h0000_007F; #1;
    step(); i_ack = 1'b0; drive_req(1'b1, 3'b010, 32'h0000_0010, 32'h5555_5555); #1;
    check("done_ign_ld_valid", o_ld_valid, 1'b1);
    check("done_ign_ld_data", o_ld_data, 32'h0000_007F);
    check("done_ign_stall", o_stall, 1'b0);
    step(); clear_req(); #1;
    check("done_ign_state", o_dbg_state, S_IDLE);
    check("done_ign_wren", o_lsu_wren, 1'b0);

    // An ack arriving in IDLE is ignored.
    i_ack = 1'b1; i_ld_data = 32'hFFFF_FFFF;
    step(); i_ack = 1'b0; #1;
    check("idle_ack_state", o_dbg_state, S_IDLE);
    check("idle_ack_ld_valid", o_ld_valid, 1'b0);
    check("idle_ack_ld_data", o_ld_data, 32'h0000_007F);

`ifdef LSU_TIMEOUT_EN
    begin
      int rden_cycles;
      step(); drive_req(1'b0, 3'b010, 32'h0000_0000, 32'h0); #1;
      step(); clear_req(); #1;
      rden_cycles = 0;
      for (int k = 0; k < 10 && o_lsu_rden; k++) begin
        rden_cycles++;
        step(); #1;
      end
      check("to_rden_cycles", rden_cycles, 4);
      check("to_state_done", o_dbg_state, S_DONE);
      check("to_fault", o_fault, 1'b1);
      check("to_no_ld_valid", o_ld_valid, 1'b0);
      check("to_ld_data", o_ld_data, 32'h0);
      check("to_stall", o_stall, 1'b0);
      step(); #1;
      check("to_fault_pulse", o_fault, 1'b0);
      check("to_state_idle", o_dbg_state, S_IDLE);
    end
`endif

    // Reset in the second ACCESS cycle, ack the cycle after.
    step(); drive_req(1'b0, 3'b010, 32'h0000_0004, 32'h0); #1;
    step(); clear_req(); #1;
    check("rst_mid_rden1", o_lsu_rden, 1'b1);
    step(); i_rst = 1'b1; #1;
    check("rst_mid_rden2", o_lsu_rden, 1'b1);
    step(); i_rst = 1'b0; i_ack = 1'b1; i_ld_data = 32'h7777_7777; #1;
    check_reset_outputs("rst_mid");
    step(); i_ack = 1'b0; #1;
    check_reset_outputs("rst_mid_after_ack");
    check("rst_mid_exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
